// File: rtl/prog_loader.sv
// prog_loader: boot loader that streams a checksummed image into program memory,
// serves the core's fetch port and holds the core in reset until the image verifies.
module prog_loader #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int IW    = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic          in_valid,
   input  logic [IW-1:0] in_data,
   output logic          in_ready,
   input  logic [AW-1:0] addr,
   output logic [IW-1:0] inst,
   output logic          core_resetn,
   output logic          busy,
   output logic          done,
   output logic          err
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
   state_t        r_state, w_next;
   logic [AW-1:0] r_wptr;
   logic [IW-1:0] r_sum;
   logic [IW-1:0] r_mem [DEPTH];
   logic          r_core_resetn;
   logic          w_xfer, w_restart, w_write;
   logic [IW-1:0] w_sum_nxt;
   assign w_xfer    = in_valid & in_ready;
   assign w_restart = start & (r_state == S_IDLE || r_state == S_RUN || r_state == S_ERR);
   assign w_write   = w_xfer & (r_state == S_LOAD);
   assign w_sum_nxt = r_sum + in_data;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (start) w_next = S_LOAD;
         S_LOAD:       if (w_xfer && r_wptr == AW'(DEPTH - 1)) w_next = S_CHECK;
         S_CHECK:      if (w_xfer) w_next = (w_sum_nxt == '0) ? S_RUN : S_ERR;
         S_RUN, S_ERR: if (start) w_next = S_LOAD;
         default:      w_next = S_IDLE;
      endcase
   end
   // core_resetn is registered from the next state so it only rises on the edge entering RUN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_wptr        <= '0;
         r_sum         <= '0;
         r_core_resetn <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_core_resetn <= (w_next == S_RUN);
         if (w_restart) begin
            r_wptr <= '0;
            r_sum  <= '0;
         end else if (w_write) begin
            r_wptr <= r_wptr + 1'b1;
            r_sum  <= w_sum_nxt;
         end
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_write) begin
         r_mem[r_wptr] <= in_data;
      end
   end
   assign inst        = r_mem[addr];
   assign in_ready    = (r_state == S_LOAD) || (r_state == S_CHECK);
   assign busy        = in_ready;
   assign done        = (r_state == S_RUN);
   assign err         = (r_state == S_ERR);
   assign core_resetn = r_core_resetn;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader against a memory/checksum model.
module tb_prog_loader;
   logic       clk = 1'b0, resetn = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic [3:0] addr = 4'h0;
   logic       in_ready, core_resetn, busy, done, err;
   logic [7:0] inst;
   int         checks = 0, errors = 0;
   logic [7:0] mdl [16];
   logic [7:0] img [16];

   prog_loader dut (
      .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .addr(addr), .inst(inst), .core_resetn(core_resetn),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] good_ck();
      int s = 0;
      for (int i = 0; i < 16; i++) s += img[i];
      return 8'(256 - (s % 256));
   endfunction

   task automatic check_flags(input string tag, input logic [4:0] exp);
      logic [4:0] got = {core_resetn, in_ready, busy, done, err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s flags{crst,rdy,busy,done,err} got %b exp %b", tag, got, exp);
      end
   endtask

   task automatic check_mem(input string tag);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1;
         checks++;
         if (inst !== mdl[a]) begin
            errors++;
            $display("FAIL %s inst[%0d] got %h exp %h", tag, a, inst, mdl[a]);
         end
      end
   endtask

   task automatic do_start(input string tag);
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      check_flags({tag, "_start"}, 5'b01100);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse, input int idx);
      int w = 0;
      @(negedge clk);
      while ($urandom_range(99) < gap) begin
         in_valid = 1'b0;
         start = pulse && ($urandom_range(2) == 0);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = b;
      start = pulse && ($urandom_range(2) == 0);
      if (idx >= 0) addr = 4'(idx);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_byte in_ready timeout got %b exp 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      start = 1'b0;
      if (idx >= 0) begin
         checks++;
         if (inst !== b) begin
            errors++;
            $display("FAIL write_visible inst[%0d] got %h exp %h", idx, inst, b);
         end
      end
   endtask

   task automatic load_image(input string tag, input logic [7:0] ck, input int gap, input bit pulse);
      int  s = 0;
      bit  ok;
      do_start(tag);
      for (int k = 0; k < 16; k++) begin
         send_byte(img[k], gap, pulse, k);
         mdl[k] = img[k];
         s += img[k];
         check_flags({tag, "_loading"}, 5'b01100);
      end
      send_byte(ck, gap, pulse, -1);
      ok = ((s + ck) % 256) == 0;
      check_flags({tag, "_end"}, ok ? 5'b10010 : 5'b00001);
   endtask

   task automatic test_reset;
      #2 resetn = 1'b0;
      #1 check_flags("reset_async", 5'b00000);
      foreach (mdl[i]) mdl[i] = 8'h00;
      check_mem("reset_mem");
      @(negedge clk) resetn = 1'b1;
      @(posedge clk) #1 check_flags("reset_idle", 5'b00000);
   endtask

   task automatic test_good_load;
      foreach (img[i]) img[i] = 8'(i);
      load_image("good", 8'h88, 0, 0);
      check_mem("good_mem");
   endtask

   task automatic test_bad_checksum;
      foreach (img[i]) img[i] = 8'(i);
      load_image("bad", 8'h87, 0, 0);
      check_mem("bad_mem");
      load_image("bad_retry", 8'h88, 0, 0);
   endtask

   task automatic test_backpressure;
      for (int r = 0; r < 3; r++) begin
         foreach (img[i]) img[i] = 8'($urandom);
         load_image("bp", good_ck(), 40, 1);
         check_mem("bp_mem");
      end
   endtask

   task automatic test_reload;
      foreach (img[i]) img[i] = 8'(8'hF0 + i);
      check_flags("reload_pre", 5'b10010);
      load_image("reload", 8'h88, 0, 0);
      check_mem("reload_mem");
   endtask

   task automatic test_reset_midload;
      do_start("midrst");
      for (int k = 0; k < 5; k++) send_byte(8'($urandom | 1), 0, 0, k);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hAA;
      #2 resetn = 1'b0;
      #1 check_flags("midrst_async", 5'b00000);
      in_valid = 1'b0;
      foreach (mdl[i]) mdl[i] = 8'h00;
      check_mem("midrst_mem");
      @(negedge clk) resetn = 1'b1;
      @(posedge clk) #1 check_flags("midrst_idle", 5'b00000);
      foreach (img[i]) img[i] = 8'($urandom);
      load_image("midrst_load", good_ck(), 20, 0);
      check_mem("midrst_load_mem");
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         foreach (img[i]) img[i] = 8'($urandom);
         load_image("rand", ($urandom_range(1) == 0) ? good_ck() : 8'(good_ck() + 8'($urandom_range(1, 255))), 25, 1);
         check_mem("rand_mem");
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_backpressure();
      test_reload();
      test_reset_midload();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1);
   end
endmodule
